// File: rtl/kyber_coef_packer.sv
// Packs reduced Kyber coefficients four-per-word into a 48-bit SDP buffer.
// A frame is WORDS words written to consecutive (7-bit wrapping) addresses from base_addr.
module kyber_coef_packer #(
   parameter int unsigned COEF_W = 12,
   parameter int unsigned Q      = 3329,
   parameter int unsigned WORDS  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [6:0]            base_addr,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [12:0]           s_data,
   output logic                  mem_ce,
   output logic [6:0]            mem_ada,
   output logic [4*COEF_W-1:0]   mem_din,
   output logic                  busy,
   output logic                  done,
   output logic                  err_range
);

   localparam logic [12:0] QV   = 13'(Q);
   localparam logic [12:0] Q2V  = 13'(2 * Q);
   localparam logic [6:0]  LAST = 7'(WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e                state_q, state_d;
   logic [1:0]            rst_sync_q, rst_sync_d;
   logic [6:0]            base_q, base_d;
   logic [6:0]            word_idx_q, word_idx_d;
   logic [1:0]            lane_q, lane_d;
   // Lanes 0..2 only; lane 3 goes straight into mem_din with the write.
   logic [3*COEF_W-1:0]   pack_q, pack_d;
   logic                  err_q, err_d;
   logic                  mem_ce_q, mem_ce_d;
   logic [6:0]            mem_ada_q, mem_ada_d;
   logic [4*COEF_W-1:0]   mem_din_q, mem_din_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [12:0]           red_full;
   logic [COEF_W-1:0]     red;

   // Conditional subtraction of Q; inputs >= 2Q still take one subtraction and flag an error.
   always_comb begin
      red_full = (s_data >= QV) ? (s_data - QV) : s_data;
      red      = COEF_W'(red_full);
   end

   assign s_ready = (state_q == StRun);

   // Frame FSM, lane packing and registered output next-state.
   always_comb begin
      state_d    = state_q;
      rst_sync_d = {rst_sync_q[0], 1'b1};
      base_d     = base_q;
      word_idx_d = word_idx_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      err_d      = err_q;
      mem_ce_d   = 1'b0;
      mem_ada_d  = mem_ada_q;
      mem_din_d  = mem_din_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // start is only honoured once reset release has propagated through the synchronizer.
            if (start && rst_sync_q[1]) begin
               state_d    = StRun;
               base_d     = base_addr;
               word_idx_d = '0;
               lane_d     = '0;
               err_d      = 1'b0;
            end
         end
         StRun: begin
            if (s_valid) begin
               lane_d = lane_q + 2'd1;
               if (s_data >= Q2V) begin
                  err_d = 1'b1;
               end
               if (lane_q == 2'd3) begin
                  mem_ce_d   = 1'b1;
                  mem_din_d  = {red, pack_q};
                  mem_ada_d  = base_q + word_idx_q;
                  word_idx_d = word_idx_q + 7'd1;
                  if (word_idx_q == LAST) begin
                     state_d = StFin;
                  end
               end else begin
                  pack_d[32'(lane_q) * COEF_W +: COEF_W] = red;
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // State and output registers; reset asserts asynchronously and discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rst_sync_q <= '0;
         base_q     <= '0;
         word_idx_q <= '0;
         lane_q     <= '0;
         pack_q     <= '0;
         err_q      <= 1'b0;
         mem_ce_q   <= 1'b0;
         mem_ada_q  <= '0;
         mem_din_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rst_sync_q <= rst_sync_d;
         base_q     <= base_d;
         word_idx_q <= word_idx_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         err_q      <= err_d;
         mem_ce_q   <= mem_ce_d;
         mem_ada_q  <= mem_ada_d;
         mem_din_q  <= mem_din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_ce    = mem_ce_q;
   assign mem_ada   = mem_ada_q;
   assign mem_din   = mem_din_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_range = err_q;

endmodule

// File: tb/tb_kyber_coef_packer.sv
// Bench for kyber_coef_packer: scoreboard of expected buffer writes plus a reduction vector table.
module tb_kyber_coef_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [6:0]  base_addr;
   logic        s_valid;
   logic        s_ready;
   logic [12:0] s_data;
   logic        mem_ce;
   logic [6:0]  mem_ada;
   logic [47:0] mem_din;
   logic        busy;
   logic        done;
   logic        err_range;

   kyber_coef_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .mem_ce    (mem_ce),
      .mem_ada   (mem_ada),
      .mem_din   (mem_din),
      .busy      (busy),
      .done      (done),
      .err_range (err_range)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  ada;
      logic [47:0] din;
   } wr_t;

   typedef struct {
      logic [12:0] c;
      logic [11:0] r;
      logic        e;
   } vec_t;

   wr_t         sb[$];
   logic [12:0] coef[256];
   vec_t        tbl[6];
   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   logic [47:0] first_din;
   logic [6:0]  first_ada;
   logic        prev_ce = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] red(input logic [12:0] c);
      logic [12:0] t;
      t = (c >= 13'd3329) ? c - 13'd3329 : c;
      return t[11:0];
   endfunction

   // Write monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (mem_ce) begin
            chk("ce_single_cycle", {63'd0, prev_ce}, 64'd0);
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_write: got strobe ada=%0d required none", mem_ada);
            end else begin
               e = sb.pop_front();
               chk("wr_ada", {57'd0, mem_ada}, {57'd0, e.ada});
               chk("wr_din", {16'd0, mem_din}, {16'd0, e.din});
            end
            if (wr_cnt == 0) begin
               first_din = mem_din;
               first_ada = mem_ada;
            end
            wr_cnt++;
         end
         prev_ce = mem_ce;
      end else begin
         prev_ce = 1'b0;
      end
   end

   task automatic start_frame(input logic [6:0] base);
      wr_cnt = 0;
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      s_valid   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", {63'd0, busy}, 64'd1);
      chk("start_ready", {63'd0, s_ready}, 64'd1);
      chk("start_err_clear", {63'd0, err_range}, 64'd0);
   endtask

   // Feed coef[0..n-1]; expected words pushed as each fourth coefficient is driven.
   task automatic feed(input logic [6:0] base, input int n, input bit gaps, input bit spam);
      int  i = 0;
      int  guard = 0;
      wr_t w;
      while (i < n && guard < 4000) begin
         @(negedge clk);
         s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_data  = coef[i];
         start   = spam ? ($urandom_range(0, 5) == 0) : 1'b0;
         if (spam) base_addr = 7'($urandom);
         if (s_valid && s_ready) begin
            if (i % 4 == 3) begin
               w.ada = base + 7'(i / 4);
               w.din = {red(coef[i]), red(coef[i-1]), red(coef[i-2]), red(coef[i-3])};
               sb.push_back(w);
            end
            i++;
         end
         guard++;
      end
      if (i < n) begin
         n_cmp++;
         n_err++;
         $display("FAIL feed_timeout: got %0d coefficients accepted required %0d", i, n);
      end
   endtask

   task automatic run_frame(input logic [6:0] base, input bit gaps, input bit spam);
      start_frame(base);
      feed(base, 256, gaps, spam);
      @(negedge clk);
      s_valid = 1'b0;
      start   = 1'b0;
      chk("fin_ready_low", {63'd0, s_ready}, 64'd0);
      chk("fin_busy", {63'd0, busy}, 64'd1);
      chk("last_strobe", {63'd0, mem_ce}, 64'd1);
      @(negedge clk);
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("done_no_ce", {63'd0, mem_ce}, 64'd0);
      @(negedge clk);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("all_words", 64'(sb.size()), 64'd0);
      chk("word_count", 64'(wr_cnt), 64'd64);
   endtask

   task automatic ramp();
      for (int i = 0; i < 256; i++) coef[i] = 13'(i);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{c: 13'd3328, r: 12'd3328, e: 1'b0};
      tbl[1] = '{c: 13'd3329, r: 12'd0,    e: 1'b0};
      tbl[2] = '{c: 13'd6657, r: 12'd3328, e: 1'b0};
      tbl[3] = '{c: 13'd6658, r: 12'd3329, e: 1'b1};
      tbl[4] = '{c: 13'd0,    r: 12'd0,    e: 1'b0};
      tbl[5] = '{c: 13'd8191, r: 12'd766,  e: 1'b1};

      rst_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      s_valid = 1'b0;
      s_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_ce", {63'd0, mem_ce}, 64'd0);
      chk("rst_err", {63'd0, err_range}, 64'd0);
      chk("rst_ada", {57'd0, mem_ada}, 64'd0);
      chk("rst_din", {16'd0, mem_din}, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Full-rate frame from base 0.
      ramp();
      run_frame(7'd0, 1'b0, 1'b0);
      chk("word0_din", {16'd0, first_din}, 64'h0000_0030_0200_1000);
      chk("word0_ada", {57'd0, first_ada}, 64'd0);

      // Reduction and range-error vectors in lane 0 of word 0.
      for (int r = 0; r < 6; r++) begin
         ramp();
         coef[0] = tbl[r].c;
         run_frame(7'd0, 1'b0, 1'b0);
         chk("tbl_lane0", {52'd0, first_din[11:0]}, {52'd0, tbl[r].r});
         chk("tbl_err", {63'd0, err_range}, {63'd0, tbl[r].e});
      end

      // Address wrap from base 100.
      ramp();
      run_frame(7'd100, 1'b0, 1'b0);
      chk("wrap_first_ada", {57'd0, first_ada}, 64'd100);
      chk("wrap_last_ada", {57'd0, mem_ada}, 64'd35);

      // Random valid gaps and stray start pulses; must match the gap-free run.
      ramp();
      run_frame(7'd0, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      chk("no_extra_frame_busy", {63'd0, busy}, 64'd0);
      chk("no_extra_frame_wr", 64'(wr_cnt), 64'd64);

      // Reset mid-frame after 130 coefficients.
      ramp();
      start_frame(7'd0);
      feed(7'd0, 130, 1'b0, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_words", 64'(wr_cnt), 64'd32);
      chk("pre_rst_busy", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {63'd0, s_ready}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_ce", {63'd0, mem_ce}, 64'd0);
      chk("mid_rst_ada", {57'd0, mem_ada}, 64'd0);
      chk("mid_rst_din", {16'd0, mem_din}, 64'd0);
      chk("mid_rst_sb_empty", 64'(sb.size()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_no_write", 64'(wr_cnt), 64'd32);
      run_frame(7'd5, 1'b0, 1'b0);
      chk("post_rst_first_ada", {57'd0, first_ada}, 64'd5);
      chk("post_rst_word0", {16'd0, first_din}, 64'h0000_0030_0200_1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
